// File: rtl/csr_access_unit.sv
// ============================================================================
// Module      : csr_access_unit
// Description : Sequences Zicsr instructions through a four-state
//               read/modify/write handshake with a registered-read CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  funct3,
   input  logic [11:0] csr_addr,
   input  logic [31:0] rs1_val,
   input  logic [4:0]  src_idx,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_illegal,
   output logic [11:0] csr_rd_addr,
   input  logic [31:0] csr_rd_val,
   output logic        csr_write,
   output logic [11:0] csr_wr_addr,
   output logic [31:0] csr_wr_val
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      r_state;
   logic [2:0]  r_funct3;
   logic [11:0] r_csrAddr;
   logic [31:0] r_rs1Val;
   logic [4:0]  r_srcIdx;
   logic [31:0] r_respRdata;
   logic        r_respIllegal;

   logic [31:0] w_operand;
   logic [31:0] w_newVal;
   logic        w_writeEn;
   logic        w_illegal;
   logic        w_doWrite;

   always_comb begin
      w_operand = r_funct3[2] ? {27'd0, r_srcIdx} : r_rs1Val;
      w_newVal  = 32'd0;
      case (r_funct3[1:0])
         2'b01:   w_newVal = w_operand;
         2'b10:   w_newVal = csr_rd_val | w_operand;
         2'b11:   w_newVal = csr_rd_val & ~w_operand;
         default: w_newVal = 32'd0;
      endcase
      // Set/clear forms with a zero source are pure reads and never write.
      w_writeEn = (r_funct3[1:0] == 2'b01) || (r_srcIdx != 5'd0);
      w_illegal = (r_funct3[1:0] == 2'b00) ||
                  (w_writeEn && (r_csrAddr[11:10] == 2'b11));
      // Gating with rst_n keeps a reset landing in WRITE from committing.
      w_doWrite = rst_n && (r_state == WRITE) && w_writeEn && !w_illegal;
   end

   assign req_ready    = (r_state == IDLE) || !rst_n;
   assign resp_valid   = rst_n && (r_state == RESP);
   assign resp_rdata   = r_respRdata;
   assign resp_illegal = r_respIllegal;
   assign csr_rd_addr  = r_csrAddr;
   assign csr_wr_addr  = r_csrAddr;
   assign csr_write    = w_doWrite;
   assign csr_wr_val   = w_doWrite ? w_newVal : 32'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_funct3      <= 3'd0;
         r_csrAddr     <= 12'd0;
         r_rs1Val      <= 32'd0;
         r_srcIdx      <= 5'd0;
         r_respRdata   <= 32'd0;
         r_respIllegal <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_funct3  <= funct3;
                  r_csrAddr <= csr_addr;
                  r_rs1Val  <= rs1_val;
                  r_srcIdx  <= src_idx;
                  r_state   <= READ;
               end
            end
            READ: begin
               r_state <= WRITE;
            end
            WRITE: begin
               r_respRdata   <= w_illegal ? 32'd0 : csr_rd_val;
               r_respIllegal <= w_illegal;
               r_state       <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_csr_access_unit.sv
// ============================================================================
// Module      : tb_csr_access_unit
// Description : Scoreboard bench for csr_access_unit with a registered CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [31:0] rs1_val;
   logic [4:0]  src_idx;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_illegal;
   logic [11:0] csr_rd_addr;
   logic [31:0] csr_rd_val;
   logic        csr_write;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_wr_val;

   int numCompared = 0;
   int numMismatched = 0;

   typedef struct {
      logic        wr;
      logic [31:0] wval;
      logic [31:0] rdata;
      logic        ill;
   } expT;

   expT expQ[$];

   logic [31:0] csrFile [0:4095];
   logic [31:0] refMem  [0:4095];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      csr_rd_val <= csrFile[csr_rd_addr];
      if (csr_write) csrFile[csr_wr_addr] <= csr_wr_val;
   end

   csr_access_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .funct3       (funct3),
      .csr_addr     (csr_addr),
      .rs1_val      (rs1_val),
      .src_idx      (src_idx),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_illegal (resp_illegal),
      .csr_rd_addr  (csr_rd_addr),
      .csr_rd_val   (csr_rd_val),
      .csr_write    (csr_write),
      .csr_wr_addr  (csr_wr_addr),
      .csr_wr_val   (csr_wr_val)
   );

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numCompared++;
      if (obs !== exp) begin
         numMismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic expT modelOp(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [31:0] rs1, input logic [4:0] idx,
                                   input logic [31:0] old);
      expT e;
      logic [31:0] opnd;
      logic badOp, we;
      badOp = (f3 == 3'b000) || (f3 == 3'b100);
      we    = (f3 == 3'b001) || (f3 == 3'b101) || (idx != 5'd0);
      opnd  = (f3 >= 3'b100) ? {27'd0, idx} : rs1;
      e.ill = badOp || (we && addr[11:10] == 2'b11);
      e.wr  = we && !e.ill;
      case (f3)
         3'b001, 3'b101: e.wval = opnd;
         3'b010, 3'b110: e.wval = old | opnd;
         3'b011, 3'b111: e.wval = old & ~opnd;
         default:        e.wval = 32'd0;
      endcase
      e.rdata = e.ill ? 32'd0 : old;
      return e;
   endfunction

   task automatic doOp(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] idx, input int holdCycles);
      expT e, got;
      int writeCount = 0, writeCycle = -1, respCycle = -1;
      logic [31:0] wv = 32'd0;
      logic busyReady = 1'b0, strayWval = 1'b0, unstable = 1'b0;
      e = modelOp(f3, addr, rs1, idx, refMem[addr]);
      expQ.push_back(e);
      if (e.wr) refMem[addr] = e.wval;

      @(negedge clk);
      req_valid = 1'b1; funct3 = f3; csr_addr = addr; rs1_val = rs1; src_idx = idx;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      // Garbage on the request side must not disturb the operation in flight.
      req_valid = 1'($urandom); funct3 = 3'($urandom); csr_addr = 12'($urandom);
      rs1_val = $urandom; src_idx = 5'($urandom);
      for (int k = 0; k < 20 && respCycle < 0; k++) begin
         @(negedge clk);
         if (req_ready) busyReady = 1'b1;
         if (csr_write) begin
            writeCount++; writeCycle = k; wv = csr_wr_val;
         end else if (csr_wr_val != 32'd0) begin
            strayWval = 1'b1;
         end
         if (resp_valid) respCycle = k;
      end
      checkEq({tag, "_respLatency"}, respCycle, 2);
      got.rdata = resp_rdata;
      got.ill   = resp_illegal;
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         if (!resp_valid || resp_rdata !== got.rdata || resp_illegal !== got.ill ||
             req_ready || csr_write) unstable = 1'b1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkEq({tag, "_idleReady"}, req_ready, 1);
      checkEq({tag, "_idleNoValid"}, resp_valid, 0);

      e = expQ.pop_front();
      checkEq({tag, "_rdata"}, got.rdata, e.rdata);
      checkEq({tag, "_illegal"}, got.ill, e.ill);
      checkEq({tag, "_writeCount"}, writeCount, e.wr ? 1 : 0);
      if (e.wr) begin
         checkEq({tag, "_writeCycle"}, writeCycle, 1);
         checkEq({tag, "_wrVal"}, wv, e.wval);
      end
      checkEq({tag, "_busyReady"}, busyReady, 0);
      checkEq({tag, "_strayWval"}, strayWval, 0);
      if (holdCycles > 0) checkEq({tag, "_holdStable"}, unstable, 0);
   endtask

   initial begin
      logic [11:0] addrSet [4];
      logic [2:0]  f3Set [8];
      logic        noValidAfter;
      int          memBad;
      logic [31:0] v;

      addrSet = '{12'h340, 12'h341, 12'hC00, 12'h300};
      f3Set   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100};
      for (int a = 0; a < 4096; a++) begin
         v = $urandom;
         csrFile[a] = v;
         refMem[a]  = v;
      end
      csrFile[12'h340] = 32'h0000_00F0; refMem[12'h340] = 32'h0000_00F0;
      csrFile[12'hC00] = 32'hCAFE_0001; refMem[12'hC00] = 32'hCAFE_0001;

      rst_n = 1'b0; req_valid = 1'b0; funct3 = 3'd0; csr_addr = 12'd0;
      rs1_val = 32'd0; src_idx = 5'd0; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkEq("rst_reqReady", req_ready, 1);
      checkEq("rst_respValid", resp_valid, 0);
      checkEq("rst_csrWrite", csr_write, 0);
      checkEq("rst_wrVal", csr_wr_val, 0);
      checkEq("rst_rdAddr", csr_rd_addr, 0);
      checkEq("rst_wrAddr", csr_wr_addr, 0);
      checkEq("rst_rdata", resp_rdata, 0);
      checkEq("rst_illegal", resp_illegal, 0);
      rst_n = 1'b1;

      doOp("csrrs340",  3'b010, 12'h340, 32'h0000_000F, 5'd3, 0);
      doOp("csrrw340",  3'b001, 12'h340, 32'hFFFF_FFFF, 5'd7, 0);
      doOp("csrrci340", 3'b111, 12'h340, 32'h1234_5678, 5'd5, 0);
      doOp("csrrwRO",   3'b001, 12'hC00, 32'h0000_1234, 5'd1, 0);
      doOp("csrrsROrd", 3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 0);
      doOp("funct100",  3'b100, 12'h340, 32'h0000_0001, 5'd2, 0);
      doOp("holdResp",  3'b110, 12'h300, 32'd0,         5'd9, 5);
      doOp("csrrcZero", 3'b011, 12'h300, 32'hFFFF_FFFF, 5'd0, 1);
      for (int i = 0; i < 8; i++) begin
         doOp($sformatf("rand%0d", i), f3Set[$urandom_range(0, 7)], addrSet[$urandom_range(0, 3)],
              $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 2));
      end

      // Reset arriving while the unit sits in WRITE.
      @(negedge clk);
      req_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h341; rs1_val = 32'hDEAD_BEEF; src_idx = 5'd1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkEq("rstWr_writePending", csr_write, 1);
      rst_n = 1'b0;
      #1;
      checkEq("rstWr_writeGated", csr_write, 0);
      checkEq("rstWr_wrValGated", csr_wr_val, 0);
      @(negedge clk);
      checkEq("rstWr_reqReady", req_ready, 1);
      checkEq("rstWr_respValid", resp_valid, 0);
      checkEq("rstWr_csrWrite", csr_write, 0);
      rst_n = 1'b1;
      noValidAfter = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid || csr_write || !req_ready) noValidAfter = 1'b0;
      end
      checkEq("rstWr_quietAfter", noValidAfter, 1);
      checkEq("rstWr_csrUnchanged", csrFile[12'h341], refMem[12'h341]);

      memBad = 0;
      for (int a = 0; a < 4096; a++) if (csrFile[a] !== refMem[a]) memBad++;
      checkEq("csrFileContents", memBad, 0);
      checkEq("scoreboardEmpty", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
